packet_receiver: RTL and testbench

Receive side of the router's byte-serial packet link. Accepts a packet stream framed by `packet_valid` (SRC, DST, SIZE, DATA×SIZE, CRC) and writes each byte into the current slot of the input packet buffer at its fixed field offset. It validates length and XOR checksum and commits only good packets by pulsing `winc`, which advances the buffer's write pointer. It is the upstream counterpart of the buffer-draining packet sender and uses the same slot layout.

---
 rtl/packet_receiver_pkg.sv | 20 ++
 rtl/pkt_crc_xor.sv | 31 +++
 rtl/packet_receiver.sv | 187 ++++++++++++++++++
 tb/tb_packet_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/packet_receiver_pkg.sv
// Shared slot layout and receiver state encodings for the packet link.
// The buffer-draining sender uses the same field offsets.
package packet_receiver_pkg;

  localparam int OFF_SRC_ID = 0;
  localparam int OFF_DST_ID = 1;
  localparam int OFF_SIZE   = 2;
  localparam int OFF_DATA   = 3;
  localparam int SIZE_BITS  = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DST     = 3'd1,
    ST_SIZE    = 3'd2,
    ST_DATA    = 3'd3,
    ST_CRC     = 3'd4,
    ST_DISCARD = 3'd5
  } rx_state_t;

endpackage

// File: rtl/pkt_crc_xor.sv
// XOR checksum accumulator: clear, seed with first byte, or fold in a byte; 1-cycle update.
// No backpressure; clear wins over seed, seed wins over accumulate.
module pkt_crc_xor #(
  parameter int UWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              seed,
  input  logic              acc,
  input  logic [UWIDTH-1:0] din,
  output logic [UWIDTH-1:0] crc
);

  logic [UWIDTH-1:0] crc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (seed) begin
      crc_q <= din;
    end else if (acc) begin
      crc_q <= crc_q ^ din;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/packet_receiver.sv
// Byte-serial packet receiver: writes fields into the current buffer slot, commits good packets; 1-cycle registered outputs.
// No backpressure on the link; a full buffer at SRC causes the whole packet to be discarded.
module packet_receiver
  import packet_receiver_pkg::*;
#(
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 packet_valid,
  input  logic [UWIDTH-1:0]    packet_in,
  input  logic                 wfull,
  output logic                 wen,
  output logic [PTR_IN_SZ-1:0] waddr_in,
  output logic [UWIDTH-1:0]    wdata,
  output logic                 winc,
  output logic                 crc_err,
  output logic                 pkt_drop
);

  rx_state_t              state_q, state_n;
  logic [SIZE_BITS-1:0]   cnt_q, cnt_n;
  logic [PTR_IN_SZ-1:0]   off_q, off_n;
  logic                   prev_vld_q;

  logic                   wen_n, winc_n, crc_err_n, pkt_drop_n;
  logic [PTR_IN_SZ-1:0]   waddr_n;
  logic [UWIDTH-1:0]      wdata_n;

  logic                   crc_clr, crc_seed, crc_acc;
  logic [UWIDTH-1:0]      crc_val;
  logic [SIZE_BITS-1:0]   size_field;

  assign size_field = packet_in[SIZE_BITS-1:0];

  pkt_crc_xor #(.UWIDTH(UWIDTH)) u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (crc_clr),
    .seed (crc_seed),
    .acc  (crc_acc),
    .din  (packet_in),
    .crc  (crc_val)
  );

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    off_n      = off_q;
    wen_n      = 1'b0;
    waddr_n    = waddr_in;
    wdata_n    = wdata;
    winc_n     = 1'b0;
    crc_err_n  = 1'b0;
    pkt_drop_n = 1'b0;
    crc_clr    = 1'b0;
    crc_seed   = 1'b0;
    crc_acc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (packet_valid) begin
          // A byte with no idle gap before it is trailing junk of the previous packet.
          if (prev_vld_q || wfull) begin
            pkt_drop_n = 1'b1;
            state_n    = ST_DISCARD;
          end else begin
            wen_n    = 1'b1;
            waddr_n  = PTR_IN_SZ'(OFF_SRC_ID);
            wdata_n  = packet_in;
            crc_seed = 1'b1;
            state_n  = ST_DST;
          end
        end
      end

      ST_DST: begin
        if (!packet_valid) begin
          pkt_drop_n = 1'b1;
          crc_clr    = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          wen_n   = 1'b1;
          waddr_n = PTR_IN_SZ'(OFF_DST_ID);
          wdata_n = packet_in;
          crc_acc = 1'b1;
          state_n = ST_SIZE;
        end
      end

      ST_SIZE: begin
        if (!packet_valid) begin
          pkt_drop_n = 1'b1;
          crc_clr    = 1'b1;
          state_n    = ST_IDLE;
        end else if (size_field == '0) begin
          pkt_drop_n = 1'b1;
          crc_clr    = 1'b1;
          state_n    = ST_DISCARD;
        end else begin
          wen_n   = 1'b1;
          waddr_n = PTR_IN_SZ'(OFF_SIZE);
          wdata_n = packet_in;
          crc_acc = 1'b1;
          cnt_n   = size_field;
          off_n   = PTR_IN_SZ'(OFF_DATA);
          state_n = ST_DATA;
        end
      end

      ST_DATA: begin
        if (!packet_valid) begin
          pkt_drop_n = 1'b1;
          crc_clr    = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          wen_n   = 1'b1;
          waddr_n = off_q;
          wdata_n = packet_in;
          crc_acc = 1'b1;
          off_n   = off_q + PTR_IN_SZ'(1);
          cnt_n   = cnt_q - SIZE_BITS'(1);
          if (cnt_q == SIZE_BITS'(1)) begin
            state_n = ST_CRC;
          end
        end
      end

      ST_CRC: begin
        if (!packet_valid) begin
          pkt_drop_n = 1'b1;
          state_n    = ST_IDLE;
        end else begin
          wen_n   = 1'b1;
          waddr_n = off_q;
          wdata_n = packet_in;
          // Running XOR already covers SRC..last DATA, so compare before folding.
          if (packet_in == crc_val) begin
            winc_n = 1'b1;
          end else begin
            crc_err_n = 1'b1;
          end
          state_n = ST_IDLE;
        end
        crc_clr = 1'b1;
      end

      ST_DISCARD: begin
        if (!packet_valid) begin
          state_n = ST_IDLE;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      prev_vld_q <= 1'b0;
      wen        <= 1'b0;
      waddr_in   <= '0;
      wdata      <= '0;
      winc       <= 1'b0;
      crc_err    <= 1'b0;
      pkt_drop   <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      off_q      <= off_n;
      prev_vld_q <= packet_valid;
      wen        <= wen_n;
      waddr_in   <= waddr_n;
      wdata      <= wdata_n;
      winc       <= winc_n;
      crc_err    <= crc_err_n;
      pkt_drop   <= pkt_drop_n;
    end
  end

endmodule

// File: tb/tb_packet_receiver.sv
// Scoreboard bench for packet_receiver: directed packets push expected write/pulse
// events; a negedge monitor pops and compares every observed output event.
`timescale 1ns/1ps
module tb_packet_receiver;

  localparam logic [1:0] EV_WR     = 2'd0;
  localparam logic [1:0] EV_COMMIT = 2'd1;
  localparam logic [1:0] EV_CRCERR = 2'd2;
  localparam logic [1:0] EV_DROP   = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       packet_valid = 1'b0;
  logic [7:0] packet_in = 8'h00;
  logic       wfull = 1'b0;
  logic       wen;
  logic [3:0] waddr_in;
  logic [7:0] wdata;
  logic       winc;
  logic       crc_err;
  logic       pkt_drop;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  packet_receiver #(.UWIDTH(8), .PTR_IN_SZ(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .packet_valid (packet_valid),
    .packet_in    (packet_in),
    .wfull        (wfull),
    .wen          (wen),
    .waddr_in     (waddr_in),
    .wdata        (wdata),
    .winc         (winc),
    .crc_err      (crc_err),
    .pkt_drop     (pkt_drop)
  );

  function automatic string ev_str(input ev_t e);
    case (e.kind)
      EV_WR:     return $sformatf("WR[%0d]=%02h", e.addr, e.data);
      EV_COMMIT: return "WINC";
      EV_CRCERR: return "CRC_ERR";
      default:   return "PKT_DROP";
    endcase
  endfunction

  task automatic check_ev(input ev_t got);
    ev_t want;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got %s, expected nothing", ev_str(got));
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL event: got %s, expected %s", ev_str(got), ev_str(want));
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, runs away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      if (wen)      check_ev('{kind: EV_WR, addr: waddr_in, data: wdata});
      if (winc)     check_ev('{kind: EV_COMMIT, addr: 4'h0, data: 8'h00});
      if (crc_err)  check_ev('{kind: EV_CRCERR, addr: 4'h0, data: 8'h00});
      if (pkt_drop) check_ev('{kind: EV_DROP, addr: 4'h0, data: 8'h00});
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic f);
    @(posedge clk);
    #2;
    packet_valid = v;
    packet_in    = b;
    wfull        = f;
  endtask

  // Drives bytes back to back, then one idle cycle; wfull only on the SRC byte.
  task automatic send(input byte_q_t bytes, input logic full_at_src);
    foreach (bytes[i]) drive(1'b1, bytes[i], (i == 0) ? full_at_src : 1'b0);
    drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    exp_q.push_back('{kind: EV_WR, addr: 4'(a), data: d});
  endtask

  task automatic exp_pulse(input logic [1:0] k);
    exp_q.push_back('{kind: k, addr: 4'h0, data: 8'h00});
  endtask

  task automatic exp_writes(input byte_q_t bytes, input int n);
    for (int i = 0; i < n; i++) exp_wr(i, bytes[i]);
  endtask

  initial begin
    byte_q_t good, bad, full5, sz0, trunc, maxp, second, junk, rpart;
    good   = '{8'h01, 8'h02, 8'h02, 8'hA5, 8'h5A, 8'hFE};
    bad    = '{8'h01, 8'h02, 8'h02, 8'hA5, 8'h5A, 8'hFF};
    full5  = '{8'h07, 8'h08, 8'h01, 8'hAA, 8'hA4};
    sz0    = '{8'h09, 8'h0A, 8'h00, 8'h13, 8'h14};
    trunc  = '{8'h01, 8'h02, 8'h03, 8'hAB};
    maxp   = '{8'h03, 8'h04, 8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00};
    second = '{8'h05, 8'h06, 8'h01, 8'hF0, 8'hF2};
    junk   = '{8'h01, 8'h02, 8'h02, 8'hA5, 8'h5A, 8'hFE, 8'h33};
    rpart  = '{8'h01, 8'h02, 8'h03, 8'hAB, 8'hCD};

    // Reset state
    #3;
    chk("rst_wen", {7'b0, wen}, 8'h00);
    chk("rst_waddr", {4'b0, waddr_in}, 8'h00);
    chk("rst_wdata", wdata, 8'h00);
    chk("rst_winc", {7'b0, winc}, 8'h00);
    chk("rst_crc_err", {7'b0, crc_err}, 8'h00);
    chk("rst_pkt_drop", {7'b0, pkt_drop}, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    // Good packet
    exp_writes(good, 6); exp_pulse(EV_COMMIT);
    send(good, 1'b0);
    // Bad CRC
    exp_writes(bad, 6); exp_pulse(EV_CRCERR);
    send(bad, 1'b0);
    // Full at SRC, then a normal packet
    exp_pulse(EV_DROP);
    send(full5, 1'b1);
    exp_writes(good, 6); exp_pulse(EV_COMMIT);
    send(good, 1'b0);
    // SIZE=0
    exp_writes(sz0, 2); exp_pulse(EV_DROP);
    send(sz0, 1'b0);
    // Truncated after one of three DATA bytes
    exp_writes(trunc, 4); exp_pulse(EV_DROP);
    send(trunc, 1'b0);
    // Max size, then a second packet after one idle cycle
    exp_writes(maxp, 11); exp_pulse(EV_COMMIT);
    send(maxp, 1'b0);
    exp_writes(second, 5); exp_pulse(EV_COMMIT);
    send(second, 1'b0);
    // Trailing byte after CRC with valid still high
    exp_writes(junk, 6); exp_pulse(EV_COMMIT); exp_pulse(EV_DROP);
    send(junk, 1'b0);
    // Reset mid-DATA; the write of the byte sampled just before reset is cleared before the monitor sees it
    exp_writes(rpart, 4);
    foreach (rpart[i]) drive(1'b1, rpart[i], 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    packet_valid = 1'b0;
    #1;
    chk("mid_rst_wen", {7'b0, wen}, 8'h00);
    chk("mid_rst_waddr", {4'b0, waddr_in}, 8'h00);
    chk("mid_rst_wdata", wdata, 8'h00);
    chk("mid_rst_winc", {7'b0, winc}, 8'h00);
    chk("mid_rst_pkt_drop", {7'b0, pkt_drop}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    exp_writes(good, 6); exp_pulse(EV_COMMIT);
    send(good, 1'b0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, next %s", exp_q.size(), ev_str(exp_q[0]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
